// File: rtl/pipo_rr_loader_if.sv
// rtl/pipo_rr_loader_if.sv - requester/downstream bundle for the round-robin PIPO loader
interface pipo_rr_loader_if #(
  parameter int WIDTH = 4
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data_in;
  logic [3:0]         ack;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         grant_id;
  logic [7:0]         load_count;

  modport master (
    output req, data_in, out_ready,
    input  ack, out_data, out_valid, grant_id, load_count
  );

  modport slave (
    input  req, data_in, out_ready,
    output ack, out_data, out_valid, grant_id, load_count
  );
endinterface

// File: rtl/pipo_rr_loader.sv
// rtl/pipo_rr_loader.sv - round-robin arbiter loading one of four words into a shared register
module pipo_rr_loader #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  pipo_rr_loader_if.slave bus
);
  localparam int NREQ = 4;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [3:0]       r_ack;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_gid;
  logic [7:0]       r_cnt;

  logic [3:0]       w_elig;
  logic             w_found;
  logic [1:0]       w_win;
  logic             w_capture;
  logic [WIDTH-1:0] w_word;

  // A requester still seeing its ack is masked so it cannot win twice in a row.
  assign w_elig = bus.req & ~r_ack;

  // Scan from the farthest offset back to ptr so the nearest eligible index wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_elig[r_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + 2'(k);
      end
    end
  end

  assign w_word    = bus.data_in[int'(w_win)*WIDTH +: WIDTH];
  assign w_capture = w_found && ((r_state == S_IDLE) || bus.out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_ack   <= 4'd0;
      r_data  <= '0;
      r_gid   <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_ack <= 4'd0;
      if (w_capture) begin
        r_state <= S_HOLD;
        r_data  <= w_word;
        r_gid   <= w_win;
        r_ack   <= 4'b0001 << w_win;
        r_ptr   <= w_win + 2'd1;
        r_cnt   <= r_cnt + 8'd1;
      end else if (r_state == S_HOLD && bus.out_ready) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign bus.ack        = r_ack;
  assign bus.out_data   = r_data;
  assign bus.out_valid  = (r_state == S_HOLD);
  assign bus.grant_id   = r_gid;
  assign bus.load_count = r_cnt;
endmodule

// File: tb/tb_pipo_rr_loader.sv
// tb/tb_pipo_rr_loader.sv - randomized and directed self-checking bench for pipo_rr_loader
module tb_pipo_rr_loader;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipo_rr_loader_if #(.WIDTH(W)) bus();

  pipo_rr_loader #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // Reference state: what a holder of the shared register must show.
  bit       m_valid;
  int       m_data;
  int       m_gid;
  int       m_ptr;
  int       m_cnt;
  bit [3:0] m_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit [3:0] rq, input bit [15:0] d, input bit rdy);
    int win;
    if (r) begin
      m_valid = 0; m_data = 0; m_gid = 0; m_ptr = 0; m_cnt = 0; m_ack = 4'd0;
      return;
    end
    win = -1;
    for (int off = 0; off < 4; off++) begin
      int i;
      i = (m_ptr + off) % 4;
      if (win < 0 && rq[i] && !m_ack[i]) win = i;
    end
    m_ack = 4'd0;
    if (win >= 0 && (!m_valid || rdy)) begin
      m_data  = (d >> (4 * win)) & 15;
      m_gid   = win;
      m_ack   = 4'(1 << win);
      m_ptr   = (win + 1) % 4;
      m_cnt   = (m_cnt + 1) % 256;
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit [3:0] rq, input bit [15:0] d, input bit rdy);
    rst           = r;
    bus.req       = rq;
    bus.data_in   = d;
    bus.out_ready = rdy;
    @(posedge clk);
    model_step(r, rq, d, rdy);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_data", 32'(bus.out_data), 32'(m_data));
      chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
      chk("ack", 32'(bus.ack), 32'(m_ack));
      chk("load_count", 32'(bus.load_count), 32'(m_cnt));
      chk("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
    end
  end

  initial begin
    rst = 1'b1; bus.req = 4'd0; bus.data_in = 16'd0; bus.out_ready = 1'b0;
    model_step(1, 4'd0, 16'd0, 0);
    cyc(1, 4'd0, 16'd0, 0);
    check_en = 1'b1;

    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_count", 32'(bus.load_count), 32'd0);

    // single request from requester 2, downstream stalled
    cyc(0, 4'b0100, 16'h0A00, 0);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_data", 32'(bus.out_data), 32'hA);
    chk("lat_gid", 32'(bus.grant_id), 32'd2);
    chk("lat_ack", 32'(bus.ack), 32'b0100);
    cyc(0, 4'b0100, 16'h0A00, 0);
    chk("lat_ack_drop", 32'(bus.ack), 32'd0);
    chk("lat_hold", 32'(bus.out_data), 32'hA);

    // stalled hold while requests churn, then release
    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'($urandom), 16'($urandom), 0);
      chk("stall_data", 32'(bus.out_data), 32'hA);
      chk("stall_gid", 32'(bus.grant_id), 32'd2);
      chk("stall_ack", 32'(bus.ack), 32'd0);
    end
    cyc(0, 4'b1011, 16'h5678, 1);
    chk("release_gid", 32'(bus.grant_id), 32'd3);
    chk("release_data", 32'(bus.out_data), 32'h5);
    chk("release_count", 32'(bus.load_count), 32'd2);

    // reset mid-hold, then pending 1010 must go to requester 1
    cyc(1, 4'b1010, 16'h1234, 0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_count", 32'(bus.load_count), 32'd0);
    cyc(0, 4'b1010, 16'h1234, 0);
    chk("postrst_gid", 32'(bus.grant_id), 32'd1);
    chk("postrst_data", 32'(bus.out_data), 32'h3);

    // all four requesting, back-to-back rotation
    cyc(1, 4'd0, 16'd0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 4'hF, 16'h4321, 1);
      chk("rr_gid", 32'(bus.grant_id), 32'(k % 4));
      chk("rr_data", 32'(bus.out_data), 32'(k % 4 + 1));
      chk("rr_count", 32'(bus.load_count), 32'(k + 1));
    end

    // lone requester re-asserting is masked for one cycle
    cyc(1, 4'd0, 16'd0, 0);
    cyc(0, 4'b0010, 16'h00B0, 1);
    chk("mask_cap1", 32'(bus.out_valid), 32'd1);
    cyc(0, 4'b0010, 16'h00B0, 1);
    chk("mask_bubble", 32'(bus.out_valid), 32'd0);
    cyc(0, 4'b0010, 16'h00B0, 1);
    chk("mask_cap2", 32'(bus.load_count), 32'd2);

    // load_count wraps at 256
    cyc(1, 4'd0, 16'd0, 0);
    for (int k = 0; k < 256; k++) cyc(0, 4'hF, 16'($urandom), 1);
    chk("wrap_256", 32'(bus.load_count), 32'd0);
    cyc(0, 4'hF, 16'($urandom), 1);
    chk("wrap_257", 32'(bus.load_count), 32'd1);

    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom % 64) == 0, 4'($urandom), 16'($urandom), 1'($urandom));
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
